// File: rtl/lcm_unit.sv
// lcm_unit: least common multiple of the operand pair given their gcd, as (A / gcd) * B.
// A restoring divider feeds a shift-add multiplier; latency is fixed at 2W+2 cycles from the gcd edge.
module lcm_unit #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   A_in,
  input  logic [W-1:0]   B_in,
  input  logic [W-1:0]   gcd_in,
  input  logic           gcd_valid,
  output logic [2*W-1:0] lcm,
  output logic           lcm_valid,
  output logic           busy,
  output logic           error
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DIV, S_MUL, S_DONE} state_t;

  localparam int            CW   = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q;
  logic           start_dly_q;
  logic           gv_dly_q;
  logic           got_g_q;
  logic [W-1:0]   aq_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   g_q;
  logic [W:0]     rem_q;
  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] lcm_q;
  logic [CW-1:0]  cnt_q;
  logic           lcm_valid_q;
  logic           busy_q;
  logic           error_q;

  logic           start_edge;
  logic           gcd_edge;
  logic [W+1:0]   trial;
  logic           trial_ge;
  logic [W:0]     rem_d;
  logic [W-1:0]   quot_d;

  assign start_edge = start & ~start_dly_q;
  assign gcd_edge   = gcd_valid & ~gv_dly_q;

  // aq_q shifts the dividend out of its top while quotient bits enter at the bottom.
  assign trial    = {rem_q, aq_q[W-1]};
  assign trial_ge = trial >= (W+2)'(g_q);
  assign rem_d    = trial_ge ? (W+1)'(trial - (W+2)'(g_q)) : trial[W:0];
  assign quot_d   = {aq_q[W-2:0], trial_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_dly_q <= 1'b0;
      gv_dly_q    <= 1'b0;
      got_g_q     <= 1'b0;
      aq_q        <= '0;
      b_q         <= '0;
      g_q         <= '0;
      rem_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      lcm_q       <= '0;
      cnt_q       <= '0;
      lcm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      start_dly_q <= start;
      gv_dly_q    <= gcd_valid;
      lcm_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            aq_q    <= A_in;
            b_q     <= B_in;
            error_q <= 1'b0;
            got_g_q <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        // The cycle after the gcd is latched decides between the short path and the datapath.
        S_WAIT: begin
          if (!got_g_q) begin
            if (gcd_edge) begin
              g_q     <= gcd_in;
              got_g_q <= 1'b1;
            end
          end else if (g_q == '0 || aq_q == '0 || b_q == '0) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          aq_q  <= quot_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            mcand_q <= {{W{1'b0}}, quot_d};
            cnt_q   <= '0;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (b_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
          end
        end
        // acc_q is still zero on the short path, so it doubles as the zero result.
        S_DONE: begin
          lcm_q       <= acc_q;
          lcm_valid_q <= 1'b1;
          error_q     <= (g_q == '0);
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lcm       = lcm_q;
  assign lcm_valid = lcm_valid_q;
  assign busy      = busy_q;
  assign error     = error_q;
endmodule

// File: tb/tb_lcm_unit.sv
// Bench for lcm_unit: directed and random operand pairs, with expected values from
// a plain-arithmetic lcm model (a*b/gcd) and a fixed cycle latency.
module tb_lcm_unit;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   A_in = '0;
  logic [W-1:0]   B_in = '0;
  logic [W-1:0]   gcd_in = '0;
  logic           gcd_valid = 1'b0;
  logic [2*W-1:0] lcm;
  logic           lcm_valid;
  logic           busy;
  logic           error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2*W-1:0] prev_lcm = '0;

  lcm_unit #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A_in      (A_in),
    .B_in      (B_in),
    .gcd_in    (gcd_in),
    .gcd_valid (gcd_valid),
    .lcm       (lcm),
    .lcm_valid (lcm_valid),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Capture a pair, present the gcd, optionally disturb the bus, then check the result.
  task automatic run_op(input int a, input int b, input int g, input int hold, input bit inj);
    bit          short_path;
    logic [63:0] exp_lcm;
    int          lat_exp;
    int          eg;
    int          n;
    int          extra;
    bit          seen;
    logic [2*W-1:0] last_lcm;
    short_path = (a == 0 || b == 0 || g == 0);
    exp_lcm    = short_path ? 64'd0 : 64'((longint'(a) * longint'(b)) / longint'(g));
    lat_exp    = short_path ? 2 : 2 * W + 2;
    @(negedge clk);
    A_in  = W'(a);
    B_in  = W'(b);
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    A_in  = W'($urandom);
    B_in  = W'($urandom);
    check("busy_after_capture", 64'(busy), 64'd1);
    check("error_cleared", 64'(error), 64'd0);
    @(negedge clk);
    gcd_in    = W'(g);
    gcd_valid = 1'b1;
    @(negedge clk);
    eg        = cyc;
    gcd_valid = 1'b0;
    gcd_in    = W'($urandom);
    n        = 0;
    seen     = 1'b0;
    last_lcm = lcm;
    while (n < 100) begin
      if (lcm_valid) begin
        seen = 1'b1;
        break;
      end
      last_lcm = lcm;
      if (inj) begin
        if (n == 5) start = 1'b1;
        if (n == 6) start = 1'b0;
        if (n == 15) begin
          gcd_valid = 1'b1;
          gcd_in    = W'(1);
        end
        if (n == 16) gcd_valid = 1'b0;
      end
      @(negedge clk);
      n = cyc - eg;
    end
    check("valid_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(lat_exp));
    check("lcm", 64'(lcm), exp_lcm);
    check("error", 64'(error), 64'(g == 0));
    check("lcm_held", 64'(last_lcm), 64'(prev_lcm));
    $display("op a=%0d b=%0d g=%0d inj=%0d -> lcm=%0d err=%0d lat=%0d (exp lcm=%0d)",
             a, b, g, inj, lcm, error, n, exp_lcm);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (lcm_valid) extra++;
    end
    check("extra_pulse", 64'(extra), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    prev_lcm = exp_lcm[2*W-1:0];
  endtask

  task automatic reset_mid(input int a, input int b, input int g);
    int extra;
    @(negedge clk);
    A_in  = W'(a);
    B_in  = W'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    gcd_in    = W'(g);
    gcd_valid = 1'b1;
    @(negedge clk);
    gcd_valid = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_lcm", 64'(lcm), 64'd0);
    check("rst_valid", 64'(lcm_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    #1 rst = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (lcm_valid) extra++;
    end
    check("rst_no_pulse", 64'(extra), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);
    $display("reset during MUL: a=%0d b=%0d g=%0d discarded", a, b, g);
    prev_lcm = '0;
  endtask

  initial begin
    int a;
    int b;
    rst = 1'b1;
    #35;
    check("reset_lcm", 64'(lcm), 64'd0);
    check("reset_valid", 64'(lcm_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    #5 rst = 1'b0;

    run_op(752, 168, 8, 3, 1'b0);
    check("directed_15792", 64'(lcm), 64'd15792);
    run_op(33, 777, 3, 1, 1'b0);
    check("directed_8547", 64'(lcm), 64'd8547);
    run_op(1023, 1022, 1, 1, 1'b0);
    check("directed_max", 64'(lcm), 64'd1045506);
    run_op(0, 5, 5, 1, 1'b0);
    run_op(0, 0, 0, 2, 1'b0);
    run_op(600, 450, 150, 1, 1'b1);
    reset_mid(1000, 999, 1);
    run_op(40, 60, 20, 1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 1023));
      b = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      run_op(a, b, int'(ref_gcd(a, b)), int'($urandom_range(1, 3)),
             (a != 0 && b != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
